// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vending controller, the credit register and the coin hopper.
interface change_dispenser_if;
    logic [2:0] i_sum;
    logic       i_buy;
    logic       i_coin_ack;
    logic       o_busy;
    logic       o_vend;
    logic       o_reject;
    logic       o_sum_clr;
    logic       o_coin_vld;
    logic       o_coin_type;
    logic [2:0] o_change_rem;
    logic       o_err;

    modport master (
        output i_sum, i_buy, i_coin_ack,
        input  o_busy, o_vend, o_reject, o_sum_clr, o_coin_vld, o_coin_type,
               o_change_rem, o_err
    );

    modport slave (
        input  i_sum, i_buy, i_coin_ack,
        output o_busy, o_vend, o_reject, o_sum_clr, o_coin_vld, o_coin_type,
               o_change_rem, o_err
    );
endinterface

// File: rtl/change_dispenser.sv
// Vending purchase controller: checks credit, releases the product and pays change
// through a handshaked coin hopper, largest coin first, with a hopper timeout.
module change_dispenser #(
    parameter int P_PRICE   = 3,
    parameter int P_TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    change_dispenser_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, CHARGE, COIN, GAP, ERROR} state_t;

    localparam logic [2:0] PRICE    = 3'(P_PRICE);
    localparam logic [7:0] TMO_LAST = 8'(P_TIMEOUT - 1);

    state_t     state, state_next;
    logic [2:0] credit, credit_next;
    logic [2:0] change, change_next;
    logic [7:0] tmo, tmo_next;
    logic       reject_next;

    logic       busy_reg, vend_reg, reject_reg, sum_clr_reg;
    logic       coin_vld_reg, coin_type_reg, err_reg;
    logic [2:0] change_rem_reg;

    always_comb begin
        state_next  = state;
        credit_next = credit;
        change_next = change;
        tmo_next    = tmo;
        reject_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_buy) begin
                    credit_next = bus.i_sum;
                    state_next  = CHECK;
                end
            end
            CHECK: begin
                if (credit < PRICE) begin
                    reject_next = 1'b1;
                    state_next  = IDLE;
                end else begin
                    change_next = credit - PRICE;
                    state_next  = CHARGE;
                end
            end
            CHARGE: begin
                if (change != 3'd0) begin
                    tmo_next   = 8'd0;
                    state_next = COIN;
                end else begin
                    state_next = IDLE;
                end
            end
            COIN: begin
                // An ack in the final allowed cycle still counts as a paid coin.
                if (bus.i_coin_ack) begin
                    change_next = change - ((change >= 3'd2) ? 3'd2 : 3'd1);
                    state_next  = GAP;
                end else if (tmo == TMO_LAST) begin
                    state_next = ERROR;
                end else begin
                    tmo_next = tmo + 8'd1;
                end
            end
            GAP: begin
                if (change != 3'd0) begin
                    tmo_next   = 8'd0;
                    state_next = COIN;
                end else begin
                    state_next = IDLE;
                end
            end
            ERROR: state_next = ERROR;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            credit         <= 3'd0;
            change         <= 3'd0;
            tmo            <= 8'd0;
            busy_reg       <= 1'b0;
            vend_reg       <= 1'b0;
            reject_reg     <= 1'b0;
            sum_clr_reg    <= 1'b0;
            coin_vld_reg   <= 1'b0;
            coin_type_reg  <= 1'b0;
            change_rem_reg <= 3'd0;
            err_reg        <= 1'b0;
        end else begin
            state          <= state_next;
            credit         <= credit_next;
            change         <= change_next;
            tmo            <= tmo_next;
            busy_reg       <= (state_next != IDLE);
            vend_reg       <= (state_next == CHARGE);
            sum_clr_reg    <= (state_next == CHARGE);
            reject_reg     <= reject_next;
            coin_vld_reg   <= (state_next == COIN);
            coin_type_reg  <= (state_next == COIN) && (change_next >= 3'd2);
            change_rem_reg <= (state_next == IDLE || state_next == CHECK) ? 3'd0 : change_next;
            err_reg        <= (state_next == ERROR);
        end
    end

    assign bus.o_busy       = busy_reg;
    assign bus.o_vend       = vend_reg;
    assign bus.o_reject     = reject_reg;
    assign bus.o_sum_clr    = sum_clr_reg;
    assign bus.o_coin_vld   = coin_vld_reg;
    assign bus.o_coin_type  = coin_type_reg;
    assign bus.o_change_rem = change_rem_reg;
    assign bus.o_err        = err_reg;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: purchase table plus timeout, held-buy and reset sequences.
module tb_change_dispenser;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    change_dispenser_if bus();

    change_dispenser #(.P_PRICE(3), .P_TIMEOUT(15)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] sum;
        int         delay;
        bit         spur;
        int         rej;
        int         vend;
        int         nick;
        int         dime;
        int         busy;
        int         seq;
        int         chg;
    } vec_t;

    typedef struct {
        int rej;
        int rej_n;
        int vend;
        int clr;
        int nick;
        int dime;
        int busy;
        int seq;
        int chg;
        int errs;
        int unstable;
        int done;
    } res_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return {22'd0, bus.o_busy, bus.o_vend, bus.o_reject, bus.o_sum_clr, bus.o_coin_vld,
                bus.o_coin_type, bus.o_change_rem, bus.o_err};
    endfunction

    // Called at a negedge; buys with the given credit and watches until the FSM is idle again.
    task automatic run_txn(input logic [2:0] sum, input int delay, input bit spur, output res_t r);
        int   vc;
        logic first_type;
        r = '{default: 0};
        r.rej_n = -1;
        vc = 0;
        first_type = 1'b0;
        bus.i_sum = sum;
        bus.i_buy = 1'b1;
        @(negedge clk);
        bus.i_buy = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (n > 0) @(negedge clk);
            if (bus.o_reject) begin
                r.rej++;
                r.rej_n = n;
            end
            if (bus.o_vend) begin
                r.vend++;
                r.chg = int'(bus.o_change_rem);
            end
            if (bus.o_sum_clr) r.clr++;
            if (bus.o_err) r.errs++;
            if (bus.o_busy) r.busy++;
            if (bus.o_coin_vld) begin
                vc++;
                if (vc == 1) first_type = bus.o_coin_type;
                else if (bus.o_coin_type != first_type) r.unstable++;
                if (vc == delay + 1) begin
                    bus.i_coin_ack = 1'b1;
                    if (bus.o_coin_type) r.dime++;
                    else r.nick++;
                    r.seq = (r.seq << 3) | int'(bus.o_change_rem);
                end else begin
                    bus.i_coin_ack = 1'b0;
                end
            end else begin
                vc = 0;
                bus.i_coin_ack = spur && bus.o_busy;
            end
            if (!bus.o_busy) begin
                r.done = 1;
                break;
            end
        end
        bus.i_coin_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int   cnt_a, cnt_b, cnt_c;
        int   seen;

        //            sum   dly spur rej vend nick dime busy seq    chg
        vecs[0] = '{3'd5, 2,  1'b0, 0,  1,   0,   1,   6,   'o2,   2};
        vecs[1] = '{3'd2, 0,  1'b0, 1,  0,   0,   0,   1,   0,     0};
        vecs[2] = '{3'd7, 0,  1'b0, 0,  1,   0,   2,   6,   'o42,  4};
        vecs[3] = '{3'd3, 0,  1'b0, 0,  1,   0,   0,   2,   0,     0};
        vecs[4] = '{3'd4, 14, 1'b0, 0,  1,   1,   0,   18,  'o1,   1};
        vecs[5] = '{3'd6, 1,  1'b0, 0,  1,   1,   1,   8,   'o31,  3};
        vecs[6] = '{3'd0, 0,  1'b0, 1,  0,   0,   0,   1,   0,     0};
        vecs[7] = '{3'd7, 1,  1'b1, 0,  1,   0,   2,   8,   'o42,  4};
        vecs[8] = '{3'd4, 0,  1'b0, 0,  1,   1,   0,   4,   'o1,   1};
        vecs[9] = '{3'd6, 3,  1'b1, 0,  1,   1,   1,   12,  'o31,  3};

        rst = 1'b1;
        bus.i_sum = 3'd0;
        bus.i_buy = 1'b0;
        bus.i_coin_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", outs(), 0);
        rst = 1'b0;

        // First purchase is requested in the very first cycle after reset release.
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].sum, vecs[i].delay, vecs[i].spur, r);
            check($sformatf("v%0d_done", i), r.done, 1);
            check($sformatf("v%0d_reject", i), r.rej, vecs[i].rej);
            if (vecs[i].rej != 0) check($sformatf("v%0d_reject_cycle", i), r.rej_n, 1);
            check($sformatf("v%0d_vend", i), r.vend, vecs[i].vend);
            check($sformatf("v%0d_sum_clr", i), r.clr, vecs[i].vend);
            check($sformatf("v%0d_nickels", i), r.nick, vecs[i].nick);
            check($sformatf("v%0d_dimes", i), r.dime, vecs[i].dime);
            check($sformatf("v%0d_busy_cycles", i), r.busy, vecs[i].busy);
            check($sformatf("v%0d_rem_seq", i), r.seq, vecs[i].seq);
            check($sformatf("v%0d_rem_charge", i), r.chg, vecs[i].chg);
            check($sformatf("v%0d_err", i), r.errs, 0);
            check($sformatf("v%0d_type_stable", i), r.unstable, 0);
        end

        // Buy held high: one purchase per IDLE visit.
        bus.i_sum = 3'd3;
        bus.i_buy = 1'b1;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        repeat (9) begin
            @(negedge clk);
            cnt_a += int'(bus.o_vend);
            cnt_b += int'(bus.o_busy);
            cnt_c += int'(bus.o_sum_clr);
        end
        bus.i_buy = 1'b0;
        check("held_buy_vends", cnt_a, 3);
        check("held_buy_busy", cnt_b, 6);
        check("held_buy_sum_clr", cnt_c, 3);
        @(negedge clk);
        check("held_buy_idle", int'(bus.o_busy), 0);

        // Hopper never acknowledges: timeout after 15 presentation cycles.
        bus.i_sum = 3'd4;
        bus.i_buy = 1'b1;
        @(negedge clk);
        bus.i_buy = 1'b0;
        cnt_a = 0;
        seen = 0;
        for (int n = 0; n < 60; n++) begin
            if (n > 0) @(negedge clk);
            if (bus.o_err) begin
                seen = 1;
                break;
            end
            if (bus.o_coin_vld) cnt_a++;
        end
        check("timeout_err_seen", seen, 1);
        check("timeout_vld_cycles", cnt_a, 15);
        check("timeout_vld_low", int'(bus.o_coin_vld), 0);
        check("timeout_busy", int'(bus.o_busy), 1);
        check("timeout_rem", int'(bus.o_change_rem), 1);

        bus.i_sum = 3'd7;
        bus.i_buy = 1'b1;
        bus.i_coin_ack = 1'b1;
        cnt_b = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.o_err && bus.o_busy && !bus.o_coin_vld && !bus.o_vend &&
                bus.o_change_rem == 3'd1) cnt_b++;
        end
        check("error_sticky", cnt_b, 5);
        bus.i_buy = 1'b0;
        bus.i_coin_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("error_reset_err", int'(bus.o_err), 0);
        check("error_reset_outputs", outs(), 0);
        rst = 1'b0;

        // Reset while a coin is being presented abandons the change.
        bus.i_sum = 3'd7;
        bus.i_buy = 1'b1;
        @(negedge clk);
        bus.i_buy = 1'b0;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.o_coin_vld) begin
                seen = 1;
                break;
            end
        end
        check("midcoin_vld_seen", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midcoin_reset_outputs", outs(), 0);
        rst = 1'b0;
        run_txn(3'd3, 0, 1'b0, r);
        check("after_reset_done", r.done, 1);
        check("after_reset_vend", r.vend, 1);
        check("after_reset_busy", r.busy, 2);
        check("after_reset_coins", r.nick + r.dime, 0);
        check("after_reset_reject", r.rej, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
